i2s_frame_ctrl: RTL

//  I2S master frame sequencer between the APB4 register/FIFO side and the pins.

---
 rtl/i2s_frame_ctrl_pkg.sv | 30 +++
 rtl/i2s_frame_ctrl_clkgen.sv | 43 ++++
 rtl/i2s_frame_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/i2s_frame_ctrl_pkg.sv
// Shared definitions for the I2S frame controller: FSM encoding, slot width and word-length codes.
package i2s_frame_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_PRIME = 2'd1;
  localparam state_t ST_RUN   = 2'd2;

  localparam int I2S_SLOT_W = 32;

  localparam logic [1:0] WLEN_8  = 2'd0;
  localparam logic [1:0] WLEN_16 = 2'd1;
  localparam logic [1:0] WLEN_24 = 2'd2;
  localparam logic [1:0] WLEN_32 = 2'd3;

  function automatic logic [5:0] wlen_bits(input logic [1:0] wlen);
    logic [2:0] n;
    n = {1'b0, wlen} + 3'd1;
    return {n, 3'b000};
  endfunction

  // Unused low bits of a slot: left shift on transmit, right shift on receive.
  function automatic logic [4:0] wlen_pad(input logic [1:0] wlen);
    logic [1:0] p;
    p = 2'd3 - wlen;
    return {p, 3'b000};
  endfunction

endpackage

// File: rtl/i2s_frame_ctrl_clkgen.sv
// SCK divider: toggles sck every div+1 enabled cycles; rise/fall strobe in the cycle before the edge.
// clr holds sck low and the counter at zero; strobes are combinational from registered state.
module i2s_frame_ctrl_clkgen
  import i2s_frame_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 sck,
  output logic                 rise,
  output logic                 fall
);

  logic [DIV_WIDTH-1:0] cnt;
  logic                 tc;

  // >= rather than == so a smaller divider picked up mid-run cannot strand the counter.
  assign tc   = en && (cnt >= div);
  assign rise = tc && !sck;
  assign fall = tc && sck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (en) begin
      if (tc) begin
        cnt <= '0;
        sck <= ~sck;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_frame_ctrl.sv
// I2S master frame sequencer: valid/ready sample pop into a hold register, MSB-first serialiser, 64 SCK frames.
// Define I2S_RX_EN to add the sd_i deserialiser; otherwise the rx outputs are tied low.
module i2s_frame_ctrl
  import i2s_frame_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic [1:0]            wlen_i,
  input  logic                  mono_i,
  input  logic                  tx_valid_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic                  tx_ready_o,
  output logic                  rx_valid_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_lr_o,
  output logic                  underrun_o,
  output logic                  busy_o,
  output logic                  sck_o,
  output logic                  ws_o,
  output logic                  sd_o,
  input  logic                  sd_i
);

  state_t                  state;
  logic [DIV_WIDTH-1:0]    div_q;
  logic [1:0]              wlen_q;
  logic                    mono_q;
  logic [5:0]              bcnt;
  logic [I2S_SLOT_W-1:0]   shreg;
  logic [I2S_SLOT_W-1:0]   mono_word;
  logic [DATA_WIDTH-1:0]   hold_dat;
  logic                    hold_full;

  logic                    sck, rise, fall;
  logic                    run, start, stop;
  logic                    load_l, load_r, load, reuse, take, pop;
  logic [4:0]              pad_ld;
  logic [I2S_SLOT_W-1:0]   fresh;

  assign run    = (state == ST_RUN);
  assign start  = (state == ST_PRIME) && en_i && hold_full;
  assign stop   = run && fall && (bcnt == 6'd63) && !en_i;
  assign load_l = start || (run && fall && (bcnt == 6'd63) && en_i);
  assign load_r = run && fall && (bcnt == 6'd31);
  assign load   = load_l || load_r;
  assign reuse  = load_r && mono_q;
  assign take   = load && !reuse && hold_full;
  assign pop    = tx_valid_i && tx_ready_o;

  // Left loads see the live word length because the configuration is re-latched on that same edge.
  assign pad_ld = wlen_pad(load_l ? wlen_i : wlen_q);
  assign fresh  = take ? I2S_SLOT_W'(hold_dat << pad_ld) : '0;

  i2s_frame_ctrl_clkgen #(.DIV_WIDTH(DIV_WIDTH)) u_clkgen (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .en    (run),
    .clr   (!run),
    .div   (div_q),
    .sck   (sck),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (en_i) state <= ST_PRIME;
        ST_PRIME: if (!en_i) state <= ST_IDLE;
                  else if (hold_full) state <= ST_RUN;
        ST_RUN:   if (stop) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q  <= '0;
      wlen_q <= WLEN_8;
      mono_q <= 1'b0;
    end else if (load_l) begin
      div_q  <= div_i;
      wlen_q <= wlen_i;
      mono_q <= mono_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bcnt <= '0;
    end else if (!run || stop) begin
      bcnt <= '0;
    end else if (fall) begin
      bcnt <= bcnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shreg     <= '0;
      mono_word <= '0;
    end else begin
      if (load) shreg <= reuse ? mono_word : fresh;
      else if (stop) shreg <= '0;
      else if (run && fall) shreg <= {shreg[I2S_SLOT_W-2:0], 1'b0};
      if (load_l) mono_word <= fresh;
    end
  end

  // A pop can only land while hold is empty, so it never collides with a take.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold_full  <= 1'b0;
      hold_dat   <= '0;
      underrun_o <= 1'b0;
    end else begin
      if (pop) begin
        hold_full <= 1'b1;
        hold_dat  <= tx_data_i;
      end else if (take) begin
        hold_full <= 1'b0;
      end
      underrun_o <= load && !reuse && !hold_full;
    end
  end

  assign tx_ready_o = !hold_full && (state != ST_IDLE);
  assign busy_o     = (state != ST_IDLE);
  assign sck_o      = sck;
  // WS is bit 5 of bcnt+1: high from bcnt 31 through 62.
  assign ws_o       = run && (bcnt[5] ? (bcnt != 6'd63) : (bcnt == 6'd31));
  assign sd_o       = run && shreg[I2S_SLOT_W-1];

`ifdef I2S_RX_EN
  logic [I2S_SLOT_W-1:0] cap;
  logic [I2S_SLOT_W-1:0] cap_nxt;

  assign cap_nxt = {cap[I2S_SLOT_W-2:0], sd_i};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cap        <= '0;
      rx_valid_o <= 1'b0;
      rx_data_o  <= '0;
      rx_lr_o    <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      if (run && rise) begin
        cap <= cap_nxt;
        if (bcnt[4:0] == 5'd31) begin
          rx_valid_o <= 1'b1;
          rx_data_o  <= DATA_WIDTH'(cap_nxt >> wlen_pad(wlen_q));
          rx_lr_o    <= bcnt[5];
        end
      end
    end
  end
`else
  logic unused_rx;
  assign unused_rx  = sd_i;
  assign rx_valid_o = 1'b0;
  assign rx_data_o  = '0;
  assign rx_lr_o    = 1'b0;
`endif

endmodule
